// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan / UART bridge: Tx FSM states and
// the active-low hex-to-segment table.
`default_nettype none

package seg_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_RDY  = 3'd1,
    S_WRITE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } tx_state_e;

  // {a,b,c,d,e,f,g}, active-low; entry 15 is listed first
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_uart_bridge_if.sv
// Bundle of UART byte, send-request and display-pin signals around the bridge.
`default_nettype none

interface seg_scan_uart_bridge_if #(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_W      = 4
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ferror;
  logic                  rx_perror;
  logic                  send;
  logic                  tx_busy;
  logic                  tx_wr;
  logic [7:0]            tx_data;
  logic                  sending;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic [ERR_W-1:0]      err_count;

  modport slave (
    input  rx_valid, rx_data, rx_ferror, rx_perror, send, tx_busy,
    output tx_wr, tx_data, sending, an, seg, dp, err_count
  );

  modport master (
    output rx_valid, rx_data, rx_ferror, rx_perror, send, tx_busy,
    input  tx_wr, tx_data, sending, an, seg, dp, err_count
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_timer.sv
// Digit scan timebase: slot counter, digit index and anti-ghost blank window.
`default_nettype none

module seg_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 16384,
  parameter int BLANK_CYCLES = 1024,
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] digit_o,
  output logic             active_o
);
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] digit_q, digit_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
      cnt_d   = '0;
      digit_d = (digit_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign active_o = (cnt_q >= CNT_W'(BLANK_CYCLES));

endmodule

`default_nettype wire

// File: rtl/seg_scan_uart_bridge.sv
// Hex display buffer fed by UART Rx, scanned onto N seven-segment digits, with a
// send request that replays a snapshot of the buffer over UART Tx, MSB first.
`default_nettype none

module seg_scan_uart_bridge
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 16384,
  parameter int BLANK_CYCLES = 1024,
  parameter int ERR_W        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  seg_scan_uart_bridge_if.slave  bus
);
  localparam int BUF_W  = 4 * NUM_DIGITS;
  localparam int NBYTES = NUM_DIGITS / 2;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  logic [IDX_W-1:0] digit_w;
  logic             active_w;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .digit_o (digit_w),
    .active_o(active_w)
  );

  tx_state_e             state_q, state_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [BUF_W-1:0]      snap_q, snap_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  tx_wr_q, tx_wr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  sending_q, sending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  always_comb begin
    buf_d     = buf_q;
    err_d     = err_q;
    state_d   = state_q;
    snap_d    = snap_q;
    byte_d    = byte_q;
    tx_data_d = tx_data_q;

    if (bus.rx_valid) begin
      if (bus.rx_ferror || bus.rx_perror) begin
        if (err_q != '1) err_d = err_q + ERR_W'(1);
      end else begin
        buf_d = BUF_W'({buf_q, bus.rx_data});
      end
    end

    // Snapshot is a shift register: the byte due next always sits at the top.
    case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          snap_d  = buf_q;
          byte_d  = '0;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (!bus.tx_busy) state_d = S_WRITE;
      end
      S_WRITE: begin
        snap_d  = snap_q << 8;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (byte_q == BYTE_W'(NBYTES - 1)) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            state_d = S_WAIT_RDY;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_wr_d   = (state_d == S_WRITE);
    sending_d = (state_d != S_IDLE);
    if (state_d == S_WRITE) tx_data_d = snap_q[BUF_W-1 -: 8];

    an_d = '1;
    if (active_w) an_d[digit_w] = 1'b0;
    seg_d = hex2seg(buf_q[{digit_w, 2'b00} +: 4]);
    dp_d  = !(active_w && (digit_w == '0) && (err_q != '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      snap_q    <= '0;
      byte_q    <= '0;
      err_q     <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      sending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      snap_q    <= snap_d;
      byte_q    <= byte_d;
      err_q     <= err_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      sending_q <= sending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.tx_wr     = tx_wr_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.sending   = sending_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.err_count = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_uart_bridge.sv
// Bench for seg_scan_uart_bridge: cycle-count display model, UART busy responder
// and Tx byte collector.
`default_nettype none

module tb_seg_scan_uart_bridge;
  localparam int N  = 4;
  localparam int S  = 16;
  localparam int B  = 4;
  localparam int EW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_scan_uart_bridge_if #(.NUM_DIGITS(N), .ERR_W(EW)) bus ();

  seg_scan_uart_bridge #(
    .NUM_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(B), .ERR_W(EW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // active-high {a..g} glyphs, index = hex value
  logic [6:0] hex_on [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Display model: cycles since reset give slot position and digit directly.
  int unsigned k;
  int          m_p, m_d, merr;
  logic [15:0] mbuf;
  logic [N-1:0] exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0; mbuf = '0; merr = 0;
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      m_p = int'(k % S);
      m_d = int'((k / S) % N);
      exp_an = '1;
      if (m_p >= B) exp_an[m_d] = 1'b0;
      exp_seg = ~hex_on[4'((mbuf >> (4 * m_d)) & 16'hF)];
      exp_dp  = !(m_d == 0 && m_p >= B && merr != 0);
      if (bus.rx_valid) begin
        if (bus.rx_ferror || bus.rx_perror) merr = (merr < 15) ? merr + 1 : 15;
        else mbuf = {mbuf[7:0], bus.rx_data};
      end
      k++;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: busy for 10 cycles after each write; records written bytes.
  logic [7:0] got_q[$];
  int busy_cnt, fall_cyc, busy_falls;
  initial begin
    bus.tx_busy = 1'b0; busy_cnt = 0; fall_cyc = 0; busy_falls = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0; bus.tx_busy = 1'b0;
      end else if (bus.tx_wr) begin
        got_q.push_back(bus.tx_data);
        busy_cnt = 10; bus.tx_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.tx_busy = 1'b0; fall_cyc = cyc; busy_falls++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic fe, input logic pe);
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_ferror = fe; bus.rx_perror = pe;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.rx_ferror = 1'b0; bus.rx_perror = 1'b0;
  endtask

  task automatic pulse_send();
    @(negedge clk); bus.send = 1'b1;
    @(negedge clk); bus.send = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && bus.sending; i++) @(negedge clk);
    vectors++;
    if (bus.sending !== 1'b0) begin
      miscompares++; $display("FAIL %s_timeout: sending=%b required 0", name, bus.sending);
    end
  endtask

  task automatic test_reset();
    logic [29:0] got, exp;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.an, bus.seg, bus.dp, bus.tx_wr, bus.tx_data, bus.sending, bus.err_count};
    exp = {4'hF, 7'h7F, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0};
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL reset_outputs: got %h required %h", got, exp);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    int low [N];
    do_reset();
    for (int d = 0; d < N; d++) low[d] = 0;
    for (int i = 0; i < N * S; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("FAIL scan_cycle%0d: an/seg/dp %b/%h/%b required %b/%h/%b",
                 i, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
      for (int d = 0; d < N; d++) if (bus.an[d] === 1'b0) low[d]++;
    end
    for (int d = 0; d < N; d++) begin
      vectors++;
      if (low[d] != S - B) begin
        miscompares++; $display("FAIL scan_low_digit%0d: %0d cycles required %0d", d, low[d], S - B);
      end
    end
  endtask

  task automatic test_rx_decode();
    int seen3 = 0, seen0 = 0;
    do_reset();
    rx_byte(8'h12, 1'b0, 1'b0);
    rx_byte(8'h34, 1'b0, 1'b0);
    for (int i = 0; i < N * S; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("FAIL rx_scan%0d: an/seg %b/%h required %b/%h", i, bus.an, bus.seg, exp_an, exp_seg);
      end
      if (bus.an === 4'b0111) begin
        seen3++;
        if (bus.seg !== 7'h4F) begin
          vectors++; miscompares++; $display("FAIL rx_digit3: seg %h required 4f", bus.seg);
        end
      end
      if (bus.an === 4'b1110) begin
        seen0++;
        if (bus.seg !== 7'h4C) begin
          vectors++; miscompares++; $display("FAIL rx_digit0: seg %h required 4c", bus.seg);
        end
      end
    end
    vectors++;
    if (seen3 != S - B || seen0 != S - B) begin
      miscompares++; $display("FAIL rx_windows: digit3 %0d digit0 %0d required %0d", seen3, seen0, S - B);
    end
  endtask

  task automatic test_errors();
    int dp_low = 0;
    rx_byte(8'hFF, 1'b0, 1'b1);
    vectors++;
    if (bus.err_count !== 4'd1) begin
      miscompares++; $display("FAIL err_first: err_count %0d required 1", bus.err_count);
    end
    for (int i = 0; i < N * S; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("FAIL err_scan%0d: an/seg/dp %b/%h/%b required %b/%h/%b",
                 i, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
      if (bus.dp === 1'b0) begin
        dp_low++;
        if (bus.an !== 4'b1110) begin
          vectors++; miscompares++; $display("FAIL err_dp_digit: dp low with an %b required 1110", bus.an);
        end
      end
      if (bus.an === 4'b1110 && bus.seg !== 7'h4C) begin
        vectors++; miscompares++; $display("FAIL err_buffer_kept: digit0 seg %h required 4c", bus.seg);
      end
    end
    vectors++;
    if (dp_low != S - B) begin
      miscompares++; $display("FAIL err_dp_window: %0d cycles required %0d", dp_low, S - B);
    end
    for (int i = 0; i < 16; i++) rx_byte(8'($urandom), 1'($urandom), 1'b1);
    vectors++;
    if (bus.err_count !== 4'd15) begin
      miscompares++; $display("FAIL err_saturate: err_count %0d required 15", bus.err_count);
    end
  endtask

  task automatic test_random_rx();
    do_reset();
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.an, bus.seg, bus.dp, bus.err_count} !== {exp_an, exp_seg, exp_dp, 4'(merr)}) begin
        miscompares++;
        $display("FAIL rand_cycle%0d: an/seg/dp/err %b/%h/%b/%0d required %b/%h/%b/%0d",
                 i, bus.an, bus.seg, bus.dp, bus.err_count, exp_an, exp_seg, exp_dp, merr);
      end
      bus.rx_valid  = ($urandom_range(0, 2) == 0);
      bus.rx_data   = 8'($urandom);
      bus.rx_ferror = ($urandom_range(0, 7) == 0);
      bus.rx_perror = ($urandom_range(0, 7) == 0);
    end
    bus.rx_valid = 1'b0; bus.rx_ferror = 1'b0; bus.rx_perror = 1'b0;
  endtask

  task automatic test_tx();
    do_reset();
    rx_byte(8'hAA, 1'b0, 1'b0);
    rx_byte(8'hBB, 1'b0, 1'b0);
    got_q.delete(); busy_falls = 0;
    pulse_send();
    vectors++;
    if (bus.sending !== 1'b1) begin
      miscompares++; $display("FAIL tx_sending_rise: sending=%b required 1", bus.sending);
    end
    wait_idle("tx");
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 8'hAA || got_q[1] !== 8'hBB) begin
      miscompares++; $display("FAIL tx_bytes: %0d bytes %p required AA BB", got_q.size(), got_q);
    end
    vectors++;
    if (busy_falls != 2 || cyc - fall_cyc != 1) begin
      miscompares++;
      $display("FAIL tx_sending_fall: busy drops %0d, fell %0d cycles after last drop, required 2 and 1",
               busy_falls, cyc - fall_cyc);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.tx_data !== 8'hBB || bus.tx_wr !== 1'b0) begin
      miscompares++; $display("FAIL tx_hold: tx_data %h tx_wr %b required bb 0", bus.tx_data, bus.tx_wr);
    end
  endtask

  task automatic test_back_to_back();
    int seen3 = 0, seen0 = 0;
    do_reset();
    rx_byte(8'hAA, 1'b0, 1'b0);
    rx_byte(8'hBB, 1'b0, 1'b0);
    got_q.delete();
    pulse_send();
    for (int i = 0; i < 100 && got_q.size() < 1; i++) @(negedge clk);
    rx_byte(8'h55, 1'b0, 1'b0);
    pulse_send();
    wait_idle("b2b");
    repeat (40) @(negedge clk);
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 8'hAA || got_q[1] !== 8'hBB) begin
      miscompares++; $display("FAIL b2b_bytes: %0d bytes %p required AA BB", got_q.size(), got_q);
    end
    for (int i = 0; i < N * S; i++) begin
      @(negedge clk);
      if (bus.an === 4'b0111) begin
        seen3++; vectors++;
        if (bus.seg !== 7'h60) begin
          miscompares++; $display("FAIL b2b_digit3: seg %h required 60", bus.seg);
        end
      end
      if (bus.an === 4'b1110) begin
        seen0++; vectors++;
        if (bus.seg !== 7'h24) begin
          miscompares++; $display("FAIL b2b_digit0: seg %h required 24", bus.seg);
        end
      end
    end
    vectors++;
    if (seen3 == 0 || seen0 == 0 || mbuf !== 16'hBB55) begin
      miscompares++; $display("FAIL b2b_display: windows %0d/%0d model buffer %h required BB55", seen3, seen0, mbuf);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    rx_byte(8'h12, 1'b0, 1'b0);
    rx_byte(8'h34, 1'b0, 1'b0);
    got_q.delete();
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h56; bus.send = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.send = 1'b0;
    wait_idle("same_edge");
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 8'h12 || got_q[1] !== 8'h34) begin
      miscompares++; $display("FAIL same_edge_bytes: %0d bytes %p required 12 34", got_q.size(), got_q);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] got, exp;
    int n;
    do_reset();
    rx_byte(8'hAA, 1'b0, 1'b0);
    rx_byte(8'hBB, 1'b0, 1'b0);
    got_q.delete();
    pulse_send();
    for (int i = 0; i < 100 && got_q.size() < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    got = {bus.an, bus.seg, bus.dp, bus.tx_wr, bus.tx_data, bus.sending, bus.err_count};
    exp = {4'hF, 7'h7F, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0};
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL reset_mid_outputs: got %h required %h", got, exp);
    end
    @(negedge clk); reset = 1'b0;
    n = got_q.size();
    repeat (60) @(negedge clk);
    vectors++;
    if (got_q.size() != n || n != 1 || bus.sending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: writes %0d then %0d sending %b required 1, 1, 0", n, got_q.size(), bus.sending);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_ferror = 1'b0;
    bus.rx_perror = 1'b0; bus.send = 1'b0;
    test_reset();
    test_scan();
    test_rx_decode();
    test_errors();
    test_random_rx();
    test_tx();
    test_back_to_back();
    test_same_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
